// File: rtl/dualmem_portb_arb_pkg.sv
// Shared types and constants for the wide-port (port B) arbiter of the
// widening frame buffer: request vectors, the registered RAM command and
// the read-return tag carried down the latency pipe.
package dualmem_arb_pkg;

  localparam int NREQ   = 2;   // requester 0 = host/AXI slave, 1 = DMA engine
  localparam int ADDR_W = 9;   // 512-word wide port
  localparam int DATA_W = 64;  // two 32-bit halves, each with its own enable
  localparam int RD_LAT = 2;   // grant -> rvalid, in cycles

  typedef logic [NREQ-1:0] req_vec_t;

  // One RAM port-B command, as presented on enb/web/addrb/dinb.
  typedef struct packed {
    logic              en;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Read-return tag: which requester the data coming back belongs to.
  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

  // Requester index to one-hot grant/valid vector.
  function automatic req_vec_t id2onehot(input logic id);
    return id ? req_vec_t'(2'b10) : req_vec_t'(2'b01);
  endfunction

endpackage

// File: rtl/dualmem_portb_arb_if.sv
// Bus bundle between the two requesters, the arbiter and RAM port B.
// The arbiter takes the slave view; requesters plus the RAM take the master view.
interface dualmem_portb_arb_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 64
) ();
  import dualmem_arb_pkg::*;

  // requester side
  req_vec_t          req_i;
  req_vec_t          lock_i;
  req_vec_t          we_i;
  logic [1:0]        be0_i;
  logic [1:0]        be1_i;
  logic [ADDR_W-1:0] addr0_i;
  logic [ADDR_W-1:0] addr1_i;
  logic [DATA_W-1:0] wdata0_i;
  logic [DATA_W-1:0] wdata1_i;
  req_vec_t          gnt_o;
  req_vec_t          rvalid_o;
  logic [DATA_W-1:0] rdata_o;

  // RAM port B side
  logic              mem_en_o;
  logic [1:0]        mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  req_i, lock_i, we_i, be0_i, be1_i, addr0_i, addr1_i,
           wdata0_i, wdata1_i, mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_i, lock_i, we_i, be0_i, be1_i, addr0_i, addr1_i,
           wdata0_i, wdata1_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/dualmem_rr_pick.sv
// Combinational two-way round-robin pick with a burst-hold override.
// last_id is the requester granted most recently; hold asks to keep it.
module dualmem_rr_pick
  import dualmem_arb_pkg::*;
(
  input  req_vec_t req,
  input  logic     last_id,
  input  logic     hold,
  output req_vec_t gnt
);

  // Held burst wins first, then contention alternates, else the lone requester.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can
    // leave gnt unassigned and infer a latch.
    gnt = '0;
    if (hold && req[last_id]) begin
      gnt = id2onehot(last_id);
    end else if (req == 2'b11) begin
      gnt = id2onehot(!last_id);
    end else begin
      gnt = req;  // 00, 01 or 10: already one-hot or empty
    end
  end

endmodule

// File: rtl/dualmem_portb_arb.sv
// Port-B arbiter of the widening frame buffer: shares the 512 x 64 port
// between the host (requester 0) and the DMA engine (requester 1) with
// round-robin arbitration, bounded burst lock, a registered RAM command
// and a fixed two-cycle read return.
// Optional feature: define DUALMEM_ARB_STATS_EN to get saturating 32-bit
// per-requester grant counters on stat_gnt0_o / stat_gnt1_o; otherwise
// both outputs are constant 0 and no counter flops exist.
module dualmem_portb_arb #(
  parameter int MAX_BURST = 8,   // 1..255 consecutive locked grants
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 64   // two 32-bit halves; must be 64
) (
  input  logic                      clk,
  input  logic                      rst,
  dualmem_portb_arb_if.slave        bus,
  output logic [31:0]               stat_gnt0_o,
  output logic [31:0]               stat_gnt1_o
);
  import dualmem_arb_pkg::*;

  localparam int               CNT_W     = 8;
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST - 1);

  // ---------------------------------------------------------------------
  // Arbitration state
  // ---------------------------------------------------------------------
  logic             rr_ptr;     // requester preferred on contention
  logic             lock_q;     // last grant asked to keep the port
  logic [CNT_W-1:0] burst_cnt;  // extra locked grants taken in a row
  logic             last_id;
  logic             hold;
  req_vec_t         pick;
  req_vec_t         gnt;
  logic             gnt_any;
  logic             gnt_id;
  logic             gnt_lock;
  logic             gnt_we;

  assign last_id = !rr_ptr;
  // The burst may continue only while it is under its budget; at the limit
  // the normal round robin gets one say, which matters only if the other
  // requester is waiting.
  assign hold    = lock_q && (burst_cnt < BURST_LIM);

  dualmem_rr_pick u_pick (
    .req     (bus.req_i),
    .last_id (last_id),
    .hold    (hold),
    .gnt     (pick)
  );

  // Grants are suppressed while reset is held so the port reads idle.
  assign gnt       = rst ? '0 : pick;
  assign gnt_any   = |gnt;
  assign gnt_id    = gnt[1];
  assign gnt_lock  = bus.lock_i[gnt_id];
  assign gnt_we    = bus.we_i[gnt_id];
  assign bus.gnt_o = gnt;

  // Round-robin pointer, lock flag and burst counter track the last grant.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      rr_ptr    <= 1'b0;
      lock_q    <= 1'b0;
      burst_cnt <= '0;
    end else if (gnt_any) begin
      rr_ptr <= !gnt_id;
      lock_q <= gnt_lock;
      if (gnt_lock && lock_q && (gnt_id == last_id)) begin
        // A lone locked requester keeps winning; park the count at the limit.
        if (burst_cnt != BURST_LIM) burst_cnt <= burst_cnt + 1'b1;
      end else begin
        burst_cnt <= '0;
      end
    end else begin
      lock_q    <= 1'b0;
      burst_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------
  // Registered RAM command
  // ---------------------------------------------------------------------
  logic [1:0]        sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  mem_cmd_t          cmd_q;

  assign sel_be    = gnt_id ? bus.be1_i    : bus.be0_i;
  assign sel_addr  = gnt_id ? bus.addr1_i  : bus.addr0_i;
  assign sel_wdata = gnt_id ? bus.wdata1_i : bus.wdata0_i;

  // Launch the granted access next cycle; idle cycles keep address and data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q <= '0;
    end else if (gnt_any) begin
      cmd_q.en    <= 1'b1;
      cmd_q.we    <= sel_be & {2{gnt_we}};
      cmd_q.addr  <= sel_addr;
      cmd_q.wdata <= sel_wdata;
    end else begin
      cmd_q.en <= 1'b0;
      cmd_q.we <= 2'b00;
    end
  end

  assign bus.mem_en_o    = cmd_q.en;
  assign bus.mem_we_o    = cmd_q.we;
  assign bus.mem_addr_o  = cmd_q.addr;
  assign bus.mem_wdata_o = cmd_q.wdata;

  // ---------------------------------------------------------------------
  // Read return: one stage for the command register, one for the RAM
  // output register. Reset empties the pipe, so in-flight reads vanish.
  // ---------------------------------------------------------------------
  rd_tag_t [RD_LAT-1:0] rd_pipe;

  // Shift a {valid, id} tag alongside each access; writes carry no tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pipe <= '0;
    end else begin
      rd_pipe[0] <= '{valid: gnt_any && !gnt_we, id: gnt_id};
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  assign bus.rvalid_o = rd_pipe[RD_LAT-1].valid ? id2onehot(rd_pipe[RD_LAT-1].id)
                                                : '0;
  // The shared data bus is forced to zero whenever nothing is returning.
  assign bus.rdata_o  = (|bus.rvalid_o) ? bus.mem_rdata_i : '0;

  // ---------------------------------------------------------------------
  // Optional grant statistics
  // ---------------------------------------------------------------------
`ifdef DUALMEM_ARB_STATS_EN
  logic [31:0] stat0_q;
  logic [31:0] stat1_q;

  // Count grants per requester, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else begin
      if (gnt[0] && (stat0_q != 32'hFFFF_FFFF)) stat0_q <= stat0_q + 32'd1;
      if (gnt[1] && (stat1_q != 32'hFFFF_FFFF)) stat1_q <= stat1_q + 32'd1;
    end
  end

  assign stat_gnt0_o = stat0_q;
  assign stat_gnt1_o = stat1_q;
`else
  assign stat_gnt0_o = '0;
  assign stat_gnt1_o = '0;
`endif

endmodule
